lamp_output_driver: RTL and testbench

- Output-side counterpart of the sensor input path: converts the phase controller's per-approach colour commands into safe lamp-drive signals for two approaches (NS, EW).
- Enforces legal colour sequencing, NS/EW conflict interlock, break-before-make dead time and minimum lamp dwell.
- On any violation, latches a fault and enters red-flash mode until software clears it.
- Sits between the FSM controller and the lamp relay pins.

---
 rtl/lamp_output_driver.sv | 229 ++++++++++++++++++++++
 tb/tb_lamp_output_driver.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lamp_output_driver.sv
// Lamp drive stage for the NS/EW approaches: checks colour sequencing and conflicts,
// inserts break-before-make dark time, enforces minimum dwell and latches a red-flash fault.
module lamp_output_driver #(
    parameter int DEAD_CYCLES = 2,
    parameter int MIN_HOLD    = 8,
    parameter int FLASH_HALF  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_ns,
    input  logic [1:0] cmd_ew,
    input  logic       fault_clear,
    output logic [2:0] lamp_ns,
    output logic [2:0] lamp_ew,
    output logic       fault,
    output logic [1:0] fault_code
);

    typedef enum logic [1:0] {
        ST_STEADY = 2'd0,
        ST_DEAD   = 2'd1,
        ST_FLASH  = 2'd2
    } state_t;

    localparam logic [1:0]  COL_RED      = 2'b00;
    localparam logic [1:0]  COL_YEL      = 2'b01;
    localparam logic [1:0]  COL_GRN      = 2'b10;
    localparam logic [1:0]  COL_RSV      = 2'b11;
    localparam logic [1:0]  FC_NONE      = 2'b00;
    localparam logic [1:0]  FC_CONFLICT  = 2'b01;
    localparam logic [1:0]  FC_ILLEGAL   = 2'b10;
    localparam logic [2:0]  LAMP_RED     = 3'b100;
    localparam logic [2:0]  LAMP_OFF     = 3'b000;
    localparam logic [15:0] HOLD_INIT    = 16'(MIN_HOLD);
    localparam logic [7:0]  DEAD_INIT    = 8'(DEAD_CYCLES);
    localparam logic [15:0] FLASH_RELOAD = 16'(FLASH_HALF - 1);

    function automatic logic step_legal(input logic [1:0] cur, input logic [1:0] nxt);
        logic ok;
        ok = 1'b0;
        if (nxt != COL_RSV) begin
            if (nxt == cur) begin
                ok = 1'b1;
            end else begin
                case (cur)
                    COL_RED: ok = (nxt == COL_GRN);
                    COL_GRN: ok = (nxt == COL_YEL);
                    COL_YEL: ok = (nxt == COL_RED);
                    default: ok = 1'b0;
                endcase
            end
        end
        return ok;
    endfunction

    function automatic logic [2:0] colour_lamp(input logic [1:0] col);
        logic [2:0] lamp;
        case (col)
            COL_RED: lamp = 3'b100;
            COL_YEL: lamp = 3'b010;
            COL_GRN: lamp = 3'b001;
            default: lamp = LAMP_OFF;
        endcase
        return lamp;
    endfunction

    state_t      state_q, state_d;
    logic [15:0] hold_q, hold_d;
    logic [7:0]  dead_q, dead_d;
    logic [15:0] flash_cnt_q, flash_cnt_d;
    logic        flash_red_q, flash_red_d;
    logic [1:0]  app_ns_q, app_ns_d;
    logic [1:0]  app_ew_q, app_ew_d;
    logic [1:0]  tgt_ns_q, tgt_ns_d;
    logic [1:0]  tgt_ew_q, tgt_ew_d;
    logic [2:0]  lamp_ns_q, lamp_ns_d;
    logic [2:0]  lamp_ew_q, lamp_ew_d;
    logic [1:0]  fcode_q, fcode_d;

    logic accept, chg_ns, chg_ew, conflict, illegal, bad_cmd, dead_done;

    // Command classification against the colours currently applied to the lamps
    always_comb begin
        accept    = cmd_valid && cmd_ready;
        chg_ns    = (cmd_ns != app_ns_q);
        chg_ew    = (cmd_ew != app_ew_q);
        conflict  = (cmd_ns != COL_RED) && (cmd_ew != COL_RED);
        illegal   = !step_legal(app_ns_q, cmd_ns) || !step_legal(app_ew_q, cmd_ew);
        bad_cmd   = conflict || illegal;
        dead_done = (dead_q <= 8'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_STEADY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STEADY: begin
                if (accept) begin
                    if (bad_cmd) begin
                        state_d = ST_FLASH;
                    end else if (chg_ns || chg_ew) begin
                        state_d = ST_DEAD;
                    end
                end
            end
            ST_DEAD:  if (dead_done) state_d = ST_STEADY;
            ST_FLASH: if (fault_clear) state_d = ST_STEADY;
            default:  state_d = ST_STEADY;
        endcase
    end

    always_comb begin
        hold_d      = hold_q;
        dead_d      = dead_q;
        flash_cnt_d = flash_cnt_q;
        flash_red_d = flash_red_q;
        app_ns_d    = app_ns_q;
        app_ew_d    = app_ew_q;
        tgt_ns_d    = tgt_ns_q;
        tgt_ew_d    = tgt_ew_q;
        lamp_ns_d   = lamp_ns_q;
        lamp_ew_d   = lamp_ew_q;
        fcode_d     = fcode_q;
        case (state_q)
            ST_STEADY: begin
                if (hold_q != 16'd0) begin
                    hold_d = hold_q - 16'd1;
                end
                if (accept) begin
                    if (bad_cmd) begin
                        fcode_d     = conflict ? FC_CONFLICT : FC_ILLEGAL;
                        flash_red_d = 1'b1;
                        flash_cnt_d = FLASH_RELOAD;
                        lamp_ns_d   = LAMP_RED;
                        lamp_ew_d   = LAMP_RED;
                    end else if (chg_ns || chg_ew) begin
                        // Only the approach that changes goes dark; the other keeps its lamp
                        dead_d   = DEAD_INIT;
                        tgt_ns_d = cmd_ns;
                        tgt_ew_d = cmd_ew;
                        if (chg_ns) lamp_ns_d = LAMP_OFF;
                        if (chg_ew) lamp_ew_d = LAMP_OFF;
                    end
                end
            end
            ST_DEAD: begin
                dead_d = dead_q - 8'd1;
                if (dead_done) begin
                    app_ns_d  = tgt_ns_q;
                    app_ew_d  = tgt_ew_q;
                    lamp_ns_d = colour_lamp(tgt_ns_q);
                    lamp_ew_d = colour_lamp(tgt_ew_q);
                    hold_d    = HOLD_INIT;
                end
            end
            ST_FLASH: begin
                if (fault_clear) begin
                    app_ns_d  = COL_RED;
                    app_ew_d  = COL_RED;
                    lamp_ns_d = LAMP_RED;
                    lamp_ew_d = LAMP_RED;
                    fcode_d   = FC_NONE;
                    hold_d    = HOLD_INIT;
                end else begin
                    if (flash_cnt_q == 16'd0) begin
                        flash_red_d = ~flash_red_q;
                        flash_cnt_d = FLASH_RELOAD;
                    end else begin
                        flash_cnt_d = flash_cnt_q - 16'd1;
                    end
                    lamp_ns_d = {flash_red_d, 2'b00};
                    lamp_ew_d = {flash_red_d, 2'b00};
                end
            end
            default: begin
                lamp_ns_d = LAMP_RED;
                lamp_ew_d = LAMP_RED;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q      <= HOLD_INIT;
            dead_q      <= 8'd0;
            flash_cnt_q <= 16'd0;
            flash_red_q <= 1'b0;
            app_ns_q    <= COL_RED;
            app_ew_q    <= COL_RED;
            lamp_ns_q   <= LAMP_RED;
            lamp_ew_q   <= LAMP_RED;
            fcode_q     <= FC_NONE;
        end else begin
            hold_q      <= hold_d;
            dead_q      <= dead_d;
            flash_cnt_q <= flash_cnt_d;
            flash_red_q <= flash_red_d;
            app_ns_q    <= app_ns_d;
            app_ew_q    <= app_ew_d;
            lamp_ns_q   <= lamp_ns_d;
            lamp_ew_q   <= lamp_ew_d;
            fcode_q     <= fcode_d;
        end
    end

    // Target colours are only consumed inside DEAD, after being loaded on acceptance
    always_ff @(posedge clk) begin
        tgt_ns_q <= tgt_ns_d;
        tgt_ew_q <= tgt_ew_d;
    end

    always_comb begin
        cmd_ready  = (state_q == ST_STEADY) && (hold_q == 16'd0);
        fault      = (state_q == ST_FLASH);
        lamp_ns    = lamp_ns_q;
        lamp_ew    = lamp_ew_q;
        fault_code = fcode_q;
    end

endmodule

// File: tb/tb_lamp_output_driver.sv
// Directed plus randomized bench for lamp_output_driver, checked against a timeline model
// that tracks absolute cycle numbers for dark, dwell and flash phases.
module tb_lamp_output_driver;

    localparam int DEAD = 2;
    localparam int HOLD = 8;
    localparam int FH   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_ns = 2'b00;
    logic [1:0] cmd_ew = 2'b00;
    logic       fault_clear = 1'b0;
    logic [2:0] lamp_ns;
    logic [2:0] lamp_ew;
    logic       fault;
    logic [1:0] fault_code;

    lamp_output_driver #(
        .DEAD_CYCLES(DEAD),
        .MIN_HOLD   (HOLD),
        .FLASH_HALF (FH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_ns     (cmd_ns),
        .cmd_ew     (cmd_ew),
        .fault_clear(fault_clear),
        .lamp_ns    (lamp_ns),
        .lamp_ew    (lamp_ew),
        .fault      (fault),
        .fault_code (fault_code)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Timeline model: cycle n = interval after the n-th clock edge since reset release
    int         cyc;
    int         ready_at;
    int         dark_end;
    int         flash_start;
    bit         m_flash;
    logic [1:0] m_code;
    int         old_ns, old_ew, new_ns, new_ew;
    bit         accepted;

    function automatic int next_of(input int c);
        return (c == 0) ? 2 : (c == 2) ? 1 : 0;
    endfunction

    function automatic bit legal(input int c, input int n);
        return (n < 3) && ((n == c) || (n == next_of(c)));
    endfunction

    function automatic logic [2:0] lamp_of(input int c);
        return (c == 0) ? 3'b100 : (c == 1) ? 3'b010 : 3'b001;
    endfunction

    function automatic bit m_ready();
        return !m_flash && (cyc >= ready_at);
    endfunction

    function automatic logic [2:0] m_lamp(input int oldc, input int newc);
        bit red;
        if (m_flash) begin
            red = (((cyc - flash_start) / FH) % 2) == 0;
            return {red, 2'b00};
        end
        if (cyc < dark_end) return (oldc != newc) ? 3'b000 : lamp_of(oldc);
        return lamp_of(newc);
    endfunction

    function automatic bit inv_ok();
        return ($countones(lamp_ns) <= 1) && ($countones(lamp_ew) <= 1) &&
               !((lamp_ns[1:0] != 2'b00) && (lamp_ew[1:0] != 2'b00));
    endfunction

    task automatic model_reset();
        cyc = 0; ready_at = HOLD; dark_end = 0; flash_start = 0;
        m_flash = 0; m_code = 2'b00;
        old_ns = 0; old_ew = 0; new_ns = 0; new_ew = 0;
    endtask

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic compare();
        chk("cmd_ready",  {2'b00, cmd_ready},  {2'b00, m_ready()});
        chk("lamp_ns",    lamp_ns,             m_lamp(old_ns, new_ns));
        chk("lamp_ew",    lamp_ew,             m_lamp(old_ew, new_ew));
        chk("fault",      {2'b00, fault},      {2'b00, m_flash});
        chk("fault_code", {1'b0, fault_code},  {1'b0, m_code});
        chk("invariant",  {2'b00, inv_ok()},   3'b001);
    endtask

    task automatic step();
        bit rdy;
        int cn, ce;
        bit conf, ill;
        rdy = m_ready();
        cn = int'(cmd_ns);
        ce = int'(cmd_ew);
        @(posedge clk);
        accepted = 0;
        if (m_flash) begin
            if (fault_clear) begin
                m_flash = 0; m_code = 2'b00;
                old_ns = 0; old_ew = 0; new_ns = 0; new_ew = 0;
                dark_end = 0; ready_at = cyc + 1 + HOLD;
            end
        end else if (cmd_valid && rdy) begin
            accepted = 1;
            conf = (cn != 0) && (ce != 0);
            ill  = !legal(new_ns, cn) || !legal(new_ew, ce);
            if (conf || ill) begin
                m_flash = 1; flash_start = cyc + 1;
                m_code = conf ? 2'b01 : 2'b10;
            end else if (cn != new_ns || ce != new_ew) begin
                old_ns = new_ns; old_ew = new_ew; new_ns = cn; new_ew = ce;
                dark_end = cyc + 1 + DEAD;
                ready_at = dark_end + HOLD;
            end
        end
        cyc++;
        #1;
        compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send(input logic [1:0] ns, input logic [1:0] ew);
        cmd_ns = ns; cmd_ew = ew; cmd_valid = 1'b1;
        accepted = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (accepted) break;
        end
        vectors++;
        assert (accepted) else begin
            miscompares++;
            $error("FAIL send_timeout cyc=%0d observed=not_accepted expected=accepted", cyc);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        fault_clear = 1'b1;
        step();
        fault_clear = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        compare();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #2;
        do_reset();
        compare();

        // Power-up: held NS-green request waits out the initial dwell
        send(2'b10, 2'b00);
        // NS to red, then EW through a full cycle
        send(2'b01, 2'b00);
        send(2'b00, 2'b00);
        send(2'b00, 2'b10);
        send(2'b00, 2'b01);
        send(2'b00, 2'b00);

        // Same-colour command is consumed; next legal one is taken immediately
        send(2'b00, 2'b00);
        send(2'b10, 2'b00);
        send(2'b01, 2'b00);
        send(2'b00, 2'b00);

        // Conflict from red/red
        send(2'b10, 2'b10);
        idle(20);
        pulse_clear();
        idle(10);

        // Illegal green to red
        send(2'b10, 2'b00);
        send(2'b00, 2'b00);
        idle(10);
        pulse_clear();
        idle(10);

        // Reserved code alone is illegal; with a non-red partner conflict wins
        send(2'b11, 2'b00);
        idle(5);
        pulse_clear();
        send(2'b11, 2'b10);
        idle(5);
        pulse_clear();

        // Reset while NS is dark
        send(2'b10, 2'b00);
        #2;
        do_reset();
        send(2'b10, 2'b00);
        send(2'b01, 2'b00);
        send(2'b00, 2'b00);

        // Randomized traffic, mostly legal progressions
        for (int i = 0; i < 1200; i++) begin
            int r;
            int ns, ew;
            r  = $urandom_range(0, 9);
            ns = new_ns;
            ew = new_ew;
            if (r < 7) begin
                if (ns != 0) ns = next_of(ns);
                else if (ew != 0) ew = next_of(ew);
                else if ($urandom_range(0, 1) == 1) ns = next_of(ns);
                else ew = next_of(ew);
            end else if (r >= 8) begin
                ns = $urandom_range(0, 3);
                ew = $urandom_range(0, 3);
            end
            cmd_ns      = 2'(ns);
            cmd_ew      = 2'(ew);
            cmd_valid   = ($urandom_range(0, 3) != 0);
            fault_clear = ($urandom_range(0, 7) == 0);
            step();
        end
        cmd_valid   = 1'b0;
        fault_clear = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
